// File: rtl/terrain_pkg.sv
// Shared terrain geometry, column word type and carve FSM states.
package terrain_pkg;

   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;

   typedef logic [SCREEN_H-1:0] terrain_col_t;

   typedef enum logic [3:0] {
      StIdle,
      StSetup,
      StChord,
      StWaitBlank,
      StRead,
      StWaitRd,
      StWrite,
      StNext,
      StDone
   } carve_state_e;

endpackage

// File: rtl/chord_mask_gen.sv
// Turns a crater centre row and half-chord height into a clipped row mask.
module chord_mask_gen #(
   parameter int unsigned SCREEN_H = terrain_pkg::SCREEN_H,
   parameter int unsigned R_BITS   = 6
) (
   input  logic [8:0]          cy_i,
   input  logic [R_BITS-1:0]   h_i,
   output logic [SCREEN_H-1:0] mask_o
);

   int lo_c;
   int hi_c;

   always_comb begin
      lo_c = int'(cy_i) - int'(h_i);
      hi_c = int'(cy_i) + int'(h_i);
      if (lo_c < 0) lo_c = 0;
      if (hi_c > int'(SCREEN_H) - 1) hi_c = int'(SCREEN_H) - 1;
      for (int i = 0; i < int'(SCREEN_H); i++) begin
         mask_o[i] = (i >= lo_c) && (i <= hi_c);
      end
   end

endmodule

// File: rtl/crater_carver.sv
// Carves a filled disc out of the terrain column store, one column per
// read-modify-write, touching the store only during VGA blanking.
module crater_carver #(
   parameter int unsigned SCREEN_W = terrain_pkg::SCREEN_W,
   parameter int unsigned SCREEN_H = terrain_pkg::SCREEN_H,
   parameter int unsigned R_BITS   = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                blank,
   input  logic                start,
   input  logic [9:0]          cx,
   input  logic [8:0]          cy,
   input  logic [R_BITS-1:0]   radius,
   output logic                busy,
   output logic                done,
   output logic [9:0]          col_addr,
   input  logic [SCREEN_H-1:0] col_rd_data,
   output logic [SCREEN_H-1:0] col_wr_data,
   output logic                col_we
);

   import terrain_pkg::*;

   localparam int unsigned SQ_W = 2 * R_BITS + 1;
   localparam logic signed [R_BITS:0] DxOne = 1;

   carve_state_e state_q, state_d;
   logic [9:0]          cx_q, cx_d;
   logic [8:0]          cy_q, cy_d;
   logic [R_BITS-1:0]   r_q, r_d;
   logic signed [R_BITS:0] dx_q, dx_d;
   logic [9:0]          x_q, x_d;
   logic [R_BITS-1:0]   h_q, h_d;
   logic [SCREEN_H-1:0] wr_q, wr_d;

   logic signed [10:0]  x_c;
   logic                x_out;
   logic signed [R_BITS:0] neg_dx;
   logic [R_BITS-1:0]   adx;
   logic [SQ_W-1:0]     h_sq, dx_sq, r_sq;
   logic                chord_gt;
   logic [SCREEN_H-1:0] mask;

   chord_mask_gen #(
      .SCREEN_H (SCREEN_H),
      .R_BITS   (R_BITS)
   ) u_mask (
      .cy_i   (cy_q),
      .h_i    (h_q),
      .mask_o (mask)
   );

   always_comb begin
      x_c    = $signed({1'b0, cx_q}) + $signed({{(10 - R_BITS){dx_q[R_BITS]}}, dx_q});
      x_out  = x_c[10] || (x_c[9:0] > 10'(SCREEN_W - 1));
      neg_dx = -dx_q;
      adx    = dx_q[R_BITS] ? neg_dx[R_BITS-1:0] : dx_q[R_BITS-1:0];
      h_sq   = SQ_W'(h_q) * SQ_W'(h_q);
      dx_sq  = SQ_W'(adx) * SQ_W'(adx);
      r_sq   = SQ_W'(r_q) * SQ_W'(r_q);
      chord_gt = (h_sq + dx_sq) > r_sq;
   end

   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      r_d     = r_q;
      dx_d    = dx_q;
      x_d     = x_q;
      h_d     = h_q;
      wr_d    = wr_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               cx_d    = cx;
               cy_d    = cy;
               r_d     = radius;
               dx_d    = -$signed({1'b0, radius});
               state_d = StSetup;
            end
         end
         StSetup: begin
            if (x_out) begin
               state_d = StNext;
            end else begin
               x_d     = x_c[9:0];
               h_d     = r_q;
               state_d = StChord;
            end
         end
         // Shrink the half-chord until (h, dx) lies on or inside the circle.
         StChord: begin
            if (chord_gt) h_d = h_q - R_BITS'(1);
            else          state_d = StWaitBlank;
         end
         StWaitBlank: if (blank) state_d = StRead;
         StRead:      state_d = StWaitRd;
         StWaitRd: begin
            wr_d    = col_rd_data & ~mask;
            state_d = StWrite;
         end
         // Losing blank here means the captured word may be stale: re-read.
         StWrite:     state_d = blank ? StNext : StWaitBlank;
         StNext: begin
            if (dx_q == $signed({1'b0, r_q})) begin
               state_d = StDone;
            end else begin
               dx_d    = dx_q + DxOne;
               state_d = StSetup;
            end
         end
         StDone:      state_d = StIdle;
         default:     state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cx_q    <= '0;
         cy_q    <= '0;
         r_q     <= '0;
         dx_q    <= '0;
         x_q     <= '0;
         h_q     <= '0;
         wr_q    <= '0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         r_q     <= r_d;
         dx_q    <= dx_d;
         x_q     <= x_d;
         h_q     <= h_d;
         wr_q    <= wr_d;
      end
   end

   always_comb begin
      busy        = (state_q != StIdle) && (state_q != StDone);
      done        = (state_q == StDone);
      col_we      = (state_q == StWrite) && blank;
      col_addr    = (state_q inside {StRead, StWaitRd, StWrite}) ? x_q : '0;
      col_wr_data = wr_q;
   end

endmodule

// File: tb/tb_crater_carver.sv
// Directed bench for crater_carver with a behavioural terrain column store.
module tb_crater_carver;

   localparam int W = 640;
   localparam int H = 480;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         blank = 1'b1;
   logic         start = 1'b0;
   logic [9:0]   cx = '0;
   logic [8:0]   cy = '0;
   logic [5:0]   radius = '0;
   logic         busy, done, col_we;
   logic [9:0]   col_addr;
   logic [H-1:0] col_rd_data;
   logic [H-1:0] col_wr_data;

   logic [H-1:0] mem [W];
   logic         fill_req = 1'b0;
   logic [9:0]   watch_addr = 10'd320;
   logic [9:0]   prev_addr = '0;

   int n_chk = 0;
   int n_fail = 0;
   int wr_cnt = 0;
   int wr_watch = 0;
   int rd_watch = 0;
   int done_cnt = 0;
   int bad_we = 0;

   crater_carver dut (
      .clk         (clk),
      .reset       (reset),
      .blank       (blank),
      .start       (start),
      .cx          (cx),
      .cy          (cy),
      .radius      (radius),
      .busy        (busy),
      .done        (done),
      .col_addr    (col_addr),
      .col_rd_data (col_rd_data),
      .col_wr_data (col_wr_data),
      .col_we      (col_we)
   );

   always #5 clk = ~clk;

   function automatic logic [H-1:0] pat(int i);
      logic [31:0] w;
      w = 32'hA5C3_0F96 ^ (i * 32'h9E37_79B9);
      return {15{w}};
   endfunction

   function automatic logic [H-1:0] rng(int lo, int hi);
      logic [H-1:0] r;
      for (int b = 0; b < H; b++) r[b] = (b >= lo) && (b <= hi);
      return r;
   endfunction

   // Column store: one-cycle read latency, write on col_we.
   always @(posedge clk) begin
      if (fill_req) begin
         for (int i = 0; i < W; i++) mem[i] <= pat(i);
      end else if (col_we) begin
         mem[col_addr] <= col_wr_data;
      end
      col_rd_data <= mem[col_addr];
   end

   always @(posedge clk) begin
      if (col_we) wr_cnt <= wr_cnt + 1;
      if (col_we && col_addr == watch_addr) wr_watch <= wr_watch + 1;
      if (col_addr == watch_addr && prev_addr != watch_addr) rd_watch <= rd_watch + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (col_we && !blank) bad_we <= bad_we + 1;
      prev_addr <= col_addr;
   end

   task automatic chk_col(string name, logic [H-1:0] act, logic [H-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_int(string name, int act, int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fill();
      @(negedge clk) fill_req = 1'b1;
      @(negedge clk) fill_req = 1'b0;
   endtask

   task automatic pulse_start(int x, int y, int r);
      @(negedge clk);
      cx = 10'(x);
      cy = 9'(y);
      radius = 6'(r);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(string name);
      int n;
      for (n = 0; n < 20000; n++) begin
         @(negedge clk);
         if (done) break;
      end
      chk_int({name, "_done_seen"}, int'(done), 1);
      chk_int({name, "_busy_at_done"}, int'(busy), 0);
      @(negedge clk);
   endtask

   task automatic wait_addr(string name, logic [9:0] a, output logic hit);
      hit = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (col_addr == a) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) chk_int({name, "_addr_timeout"}, int'(col_addr), int'(a));
   endtask

   typedef struct {
      int x, y, r, n_wr;
      int ca, ca_lo, ca_hi;
      int cb, cb_lo, cb_hi;
      int cn;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int w0, d0, rw0, ww0;
      logic hit;

      vecs[0] = '{320, 240, 3, 7, 320, 237, 243, 317, 240, 240, 316};
      vecs[1] = '{1, 100, 4, 6, 0, 97, 103, 5, 100, 100, 6};
      vecs[2] = '{50, 2, 5, 11, 50, 0, 7, 55, 2, 2, 44};
      vecs[3] = '{10, 10, 0, 1, 10, 10, 10, 10, 10, 10, 9};
      vecs[4] = '{639, 479, 2, 3, 639, 477, 479, 637, 479, 479, 636};

      #1 reset = 1'b1;
      #1;
      chk_int("rst_busy", int'(busy), 0);
      chk_int("rst_done", int'(done), 0);
      chk_int("rst_we", int'(col_we), 0);
      chk_int("rst_addr", int'(col_addr), 0);
      chk_col("rst_wr_data", col_wr_data, '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      foreach (vecs[k]) begin
         fill();
         w0 = wr_cnt;
         d0 = done_cnt;
         pulse_start(vecs[k].x, vecs[k].y, vecs[k].r);
         chk_int($sformatf("v%0d_busy_rise", k), int'(busy), 1);
         wait_done($sformatf("v%0d", k));
         chk_int($sformatf("v%0d_writes", k), wr_cnt - w0, vecs[k].n_wr);
         chk_int($sformatf("v%0d_done_pulses", k), done_cnt - d0, 1);
         chk_col($sformatf("v%0d_col%0d", k, vecs[k].ca), mem[vecs[k].ca],
                 pat(vecs[k].ca) & ~rng(vecs[k].ca_lo, vecs[k].ca_hi));
         chk_col($sformatf("v%0d_col%0d", k, vecs[k].cb), mem[vecs[k].cb],
                 pat(vecs[k].cb) & ~rng(vecs[k].cb_lo, vecs[k].cb_hi));
         chk_col($sformatf("v%0d_untouched%0d", k, vecs[k].cn), mem[vecs[k].cn], pat(vecs[k].cn));
      end

      // Same crater twice: second pass leaves the already-cleared column as is.
      fill();
      pulse_start(320, 240, 3);
      wait_done("idem_a");
      w0 = wr_cnt;
      pulse_start(320, 240, 3);
      wait_done("idem_b");
      chk_int("idem_writes", wr_cnt - w0, 7);
      chk_col("idem_col320", mem[320], pat(320) & ~rng(237, 243));
      chk_col("idem_col318", mem[318], pat(318) & ~rng(238, 242));

      // start while busy is ignored.
      fill();
      w0 = wr_cnt;
      d0 = done_cnt;
      pulse_start(320, 240, 3);
      repeat (5) @(negedge clk);
      pulse_start(100, 100, 2);
      wait_done("ign");
      chk_int("ign_writes", wr_cnt - w0, 7);
      chk_int("ign_done_pulses", done_cnt - d0, 1);
      chk_col("ign_col100", mem[100], pat(100));
      chk_int("ign_idle_busy", int'(busy), 0);

      // blank drops on the WRITE cycle of column 320.
      fill();
      w0 = wr_cnt;
      rw0 = rd_watch;
      ww0 = wr_watch;
      pulse_start(320, 240, 3);
      wait_addr("blk", 10'd320, hit);
      if (hit) begin
         @(negedge clk);
         @(negedge clk);
         blank = 1'b0;
         repeat (4) @(negedge clk);
         chk_int("blk_held_busy", int'(busy), 1);
         blank = 1'b1;
      end
      wait_done("blk");
      chk_int("blk_reads320", rd_watch - rw0, 2);
      chk_int("blk_writes320", wr_watch - ww0, 1);
      chk_int("blk_writes", wr_cnt - w0, 7);
      chk_col("blk_col320", mem[320], pat(320) & ~rng(237, 243));

      // Reset during WAIT_RD of the first column.
      fill();
      pulse_start(320, 240, 3);
      wait_addr("rst", 10'd317, hit);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_int("rst_mid_busy", int'(busy), 0);
      chk_int("rst_mid_we", int'(col_we), 0);
      chk_int("rst_mid_addr", int'(col_addr), 0);
      chk_col("rst_mid_wr_data", col_wr_data, '0);
      w0 = wr_cnt;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (50) @(negedge clk);
      chk_int("rst_no_writes", wr_cnt - w0, 0);
      chk_int("rst_idle", int'(busy), 0);
      chk_col("rst_col317", mem[317], pat(317));
      w0 = wr_cnt;
      pulse_start(320, 240, 3);
      wait_done("rst_again");
      chk_int("rst_again_writes", wr_cnt - w0, 7);
      chk_col("rst_again_col320", mem[320], pat(320) & ~rng(237, 243));

      chk_int("we_while_blank_low", bad_we, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
